// File: rtl/polymul_pkg.sv
// Shared constants and FSM state type for the polynomial-multiplier job scheduler.
package polymul_pkg;

  localparam int N_COEF         = 4;
  localparam int COEF_W         = 4;
  localparam int POLY_W         = N_COEF * COEF_W;
  localparam int TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/polymul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward with wrap,
// returning a one-hot grant and its index.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_grant_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(i_last_grant) + k) % N_REQ);
      if (!w_found && i_req_valid[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
      end
    end
  end

endmodule

// File: rtl/polymul_scheduler.sv
// Round-robin scheduler sharing one polynomial multiplier between N_REQ requesters.
// Optional WAIT watchdog enabled by defining POLYMUL_SCHED_TIMEOUT_EN.
module polymul_scheduler #(
  parameter int N_REQ          = 2,
  parameter int N_COEF         = polymul_pkg::N_COEF,
  parameter int COEF_W         = polymul_pkg::COEF_W,
  parameter int TIMEOUT_CYCLES = polymul_pkg::TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*N_COEF*COEF_W-1:0]   req_a,
  input  logic [N_REQ*N_COEF*COEF_W-1:0]   req_b,
  output logic [N_REQ-1:0]                 rsp_valid,
  input  logic [N_REQ-1:0]                 rsp_ready,
  output logic [N_COEF*COEF_W-1:0]         rsp_data,
  output logic                             rsp_err,
  output logic                             mul_start,
  output logic [N_COEF*COEF_W-1:0]         mul_a,
  output logic [N_COEF*COEF_W-1:0]         mul_b,
  input  logic                             mul_done,
  input  logic [N_COEF*COEF_W-1:0]         mul_result,
  output logic                             busy,
  output logic [7:0]                       job_count
);

  import polymul_pkg::*;

  localparam int PW    = N_COEF * COEF_W;
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("polymul_scheduler: parameter out of supported range");
  end

  state_e           r_state;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] r_owner;
  logic [PW-1:0]    r_a;
  logic [PW-1:0]    r_b;
  logic [PW-1:0]    r_rsp_data;
  logic [N_REQ-1:0] r_rsp_valid;
  logic             r_mul_start;
  logic             r_busy;
  logic [7:0]       r_job_count;

  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_req_hs;
  logic             w_rsp_hs;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req_valid  (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  // Grant is offered only in IDLE and never while reset is held, so nothing is accepted during reset.
  assign req_ready = (r_state == S_IDLE && reset) ? w_grant : '0;
  assign w_req_hs  = |(req_valid & req_ready);
  assign w_rsp_hs  = (r_state == S_RESP) && rsp_ready[r_owner];

`ifdef POLYMUL_SCHED_TIMEOUT_EN
  logic [7:0] r_timer;
  logic       r_rsp_err;
  logic       w_timeout;

  assign w_timeout = (r_timer == 8'(TIMEOUT_CYCLES - 1));
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_owner      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_data   <= '0;
      r_rsp_valid  <= '0;
      r_mul_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_job_count  <= '0;
`ifdef POLYMUL_SCHED_TIMEOUT_EN
      r_timer      <= '0;
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req_hs) begin
            r_a         <= PW'(req_a >> (PW * int'(w_grant_idx)));
            r_b         <= PW'(req_b >> (PW * int'(w_grant_idx)));
            r_owner     <= w_grant_idx;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef POLYMUL_SCHED_TIMEOUT_EN
          r_timer <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done strobe on the limit cycle still wins over the watchdog.
          if (mul_done) begin
            r_rsp_data  <= mul_result;
            r_rsp_valid <= N_REQ'(1) << r_owner;
            r_state     <= S_RESP;
`ifdef POLYMUL_SCHED_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= N_REQ'(1) << r_owner;
            r_state     <= S_RESP;
`endif
          end
`ifdef POLYMUL_SCHED_TIMEOUT_EN
          r_timer <= r_timer + 8'd1;
`endif
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid  <= '0;
            r_last_grant <= r_owner;
            r_job_count  <= r_job_count + 8'd1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mul_start = r_mul_start;
  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign busy      = r_busy;
  assign job_count = r_job_count;

endmodule

// File: tb/tb_polymul_scheduler.sv
// Scoreboard bench for polymul_scheduler with a behavioural multiplier model.
`timescale 1ns/1ps
module tb_polymul_scheduler;

  localparam int N_REQ = 2;
  localparam int NC    = 4;
  localparam int CW    = 4;
  localparam int PW    = NC * CW;
  localparam int TMO   = 8;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*PW-1:0]    req_a = '0;
  logic [N_REQ*PW-1:0]    req_b = '0;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready = '0;
  logic [PW-1:0]          rsp_data;
  logic                   rsp_err;
  logic                   mul_start;
  logic [PW-1:0]          mul_a;
  logic [PW-1:0]          mul_b;
  logic                   mul_done = 1'b0;
  logic [PW-1:0]          mul_result = '0;
  logic                   busy;
  logic [7:0]             job_count;

  polymul_scheduler #(
    .N_REQ          (N_REQ),
    .N_COEF         (NC),
    .COEF_W         (CW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .busy       (busy),
    .job_count  (job_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            owner;
    logic [PW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          sb_q[$];
  int            grant_log[$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            n_rsp = 0;
  int            n_start = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            m_last = N_REQ - 1;
  bit            mdl_en = 1'b1;
  bit            mdl_ovr_en = 1'b0;
  logic [PW-1:0] mdl_ovr_val = '0;
  int            mdl_delay = 2;
  int            mdl_late_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cyclic convolution mod (x^4 - 1), coefficients mod 16.
  function automatic logic [PW-1:0] poly_mul(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] res;
    logic [CW-1:0] coef, ai, bj;
    res = '0;
    for (int k = 0; k < NC; k++) begin
      coef = '0;
      for (int i = 0; i < NC; i++) begin
        ai   = CW'(a >> (CW * i));
        bj   = CW'(b >> (CW * ((k - i + NC) % NC)));
        coef = coef + ai * bj;
      end
      res = res | (PW'(coef) << (CW * k));
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] exp_grant(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (((v >> ((last + k) % N_REQ)) & 1) != 0) return N_REQ'(1) << ((last + k) % N_REQ);
    end
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sb_q.delete();
    m_last = N_REQ - 1;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_rsp(input int budget, output int lat);
    int k = 0;
    while (rsp_valid == '0 && k < budget) begin
      tick();
      k++;
    end
    if (rsp_valid == '0) check_eq("wait_rsp_timeout", 0, 1);
    lat = cyc - start_cyc;
  endtask

  task automatic wait_nrsp(input int target, input int budget);
    int k = 0;
    while (n_rsp < target && k < budget) begin
      tick();
      k++;
    end
    check_eq("wait_nrsp", n_rsp, target);
  endtask

  // Multiplier model: done strobe mdl_delay cycles after the start pulse, result from the live operands.
  initial begin
    int cnt = 0;
    int late_ack = 0;
    forever begin
      @(posedge clk);
      #1;
      mul_done   = 1'b0;
      mul_result = '1;
      if (!reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            mul_done   = 1'b1;
            mul_result = mdl_ovr_en ? mdl_ovr_val : poly_mul(mul_a, mul_b);
          end
        end
        if (mul_start) begin
          n_start++;
          start_cyc = cyc;
          if (mdl_en) cnt = mdl_delay;
        end
        if (mdl_late_req != late_ack) begin
          late_ack   = mdl_late_req;
          mul_done   = 1'b1;
          mul_result = 16'hBEEF;
        end
      end
    end
  end

  // Acceptance pushes the expected response; response handshake pops and compares.
  initial begin
    exp_t e;
    logic [N_REQ-1:0] g;
    forever begin
      @(negedge clk);
      if (reset) begin
        if ((req_valid & req_ready) != '0) begin
          g = exp_grant(req_valid, m_last);
          check_eq("grant", 32'(req_ready), 32'(g));
          e.owner = (req_ready[1]) ? 1 : 0;
          e.err   = 1'b0;
`ifdef POLYMUL_SCHED_TIMEOUT_EN
          e.err   = !mdl_en;
`endif
          e.data  = e.err ? '0 :
                    (mdl_ovr_en ? mdl_ovr_val :
                     poly_mul(PW'(req_a >> (PW * e.owner)), PW'(req_b >> (PW * e.owner))));
          sb_q.push_back(e);
          grant_log.push_back(e.owner);
        end
        if ((rsp_valid & rsp_ready) != '0) begin
          if (sb_q.size() == 0) begin
            check_eq("rsp_unexpected", 32'(rsp_valid), 0);
          end else begin
            e = sb_q.pop_front();
            check_eq("rsp_owner", 32'(rsp_valid), 32'(N_REQ'(1) << e.owner));
            check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
            check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
            m_last = e.owner;
          end
          n_rsp++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

  initial begin
    int            lat;
    int            s0;
    int            base;
    int            prev;
    bit            seen;
    logic [PW-1:0] held;

    // Reset state, with requests pending so req_ready gating is exercised.
    req_valid = 2'b11;
    repeat (3) tick();
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_data", 32'(rsp_data), 0);
    check_eq("rst_rsp_err", 32'(rsp_err), 0);
    check_eq("rst_mul_start", 32'(mul_start), 0);
    check_eq("rst_mul_a", 32'(mul_a), 0);
    check_eq("rst_mul_b", 32'(mul_b), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_job_count", 32'(job_count), 0);
    req_valid = '0;
    reset = 1'b1;
    tick();

    // Single job with a fixed multiplier answer.
    mdl_ovr_en  = 1'b1;
    mdl_ovr_val = 16'h1234;
    mdl_delay   = 3;
    rsp_ready   = 2'b11;
    req_a       = 32'h0000_0008;
    req_b       = 32'h0000_0865;
    req_valid   = 2'b01;
    tick();
    req_valid = '0;
    check_eq("t1_mul_start", 32'(mul_start), 1);
    check_eq("t1_mul_a", 32'(mul_a), 32'h0008);
    check_eq("t1_mul_b", 32'(mul_b), 32'h0865);
    check_eq("t1_busy", 32'(busy), 1);
    tick();
    check_eq("t1_start_pulse", 32'(mul_start), 0);
    wait_rsp(20, lat);
    check_eq("t1_latency", lat, mdl_delay + 1);
    check_eq("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("t1_rsp_data", 32'(rsp_data), 32'h1234);
    tick();
    check_eq("t1_job_count", 32'(job_count), 1);
    check_eq("t1_idle", 32'(busy), 0);
    mdl_ovr_en = 1'b0;

    // Fairness with both requesters always asking.
    do_reset();
    mdl_delay = 2;
    grant_log.delete();
    base = n_rsp;
    prev = n_rsp;
    req_a = $urandom;
    req_b = $urandom;
    req_valid = 2'b11;
    for (int k = 0; k < 200 && n_rsp < base + 4; k++) begin
      tick();
      if (n_rsp != prev) begin
        prev  = n_rsp;
        req_a = $urandom;
        req_b = $urandom;
      end
    end
    req_valid = '0;
    check_eq("fair_jobs", grant_log.size(), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) check_eq("fair_grant", grant_log[i], i % 2);

    // Back-pressure: response held while the owner is not ready.
    rsp_ready = '0;
    mdl_delay = 1;
    req_a = $urandom;
    req_b = $urandom;
    base = n_rsp;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    wait_rsp(20, lat);
    s0 = n_start;
    held = rsp_data;
    rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check_eq("bp_rsp_data", 32'(rsp_data), 32'(held));
      check_eq("bp_req_ready", 32'(req_ready), 0);
      check_eq("bp_no_restart", n_start, s0);
    end
    rsp_ready = 2'b01;
    tick();
    check_eq("bp_released", 32'(busy), 0);
    check_eq("bp_next_grant", 32'(req_ready), 32'h2);
    rsp_ready = 2'b11;
    tick();
    req_valid = '0;
    wait_nrsp(base + 2, 50);

    // Reset while WAITing for the multiplier.
    mdl_en = 1'b0;
    req_a = $urandom;
    req_b = $urandom;
    s0 = n_start;
    req_valid = 2'b11;
    for (int k = 0; k < 20 && n_start == s0; k++) tick();
    check_eq("rw_started", n_start, s0 + 1);
    tick();
    reset = 1'b0;
    sb_q.delete();
    m_last = N_REQ - 1;
    #1;
    check_eq("rw_busy", 32'(busy), 0);
    check_eq("rw_mul_a", 32'(mul_a), 0);
    check_eq("rw_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rw_rsp_data", 32'(rsp_data), 0);
    check_eq("rw_job_count", 32'(job_count), 0);
    check_eq("rw_req_ready", 32'(req_ready), 0);
    tick();
    reset = 1'b1;
    mdl_en = 1'b1;
    base = n_rsp;
    #1;
    check_eq("rw_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    wait_nrsp(base + 1, 50);

`ifdef POLYMUL_SCHED_TIMEOUT_EN
    // Watchdog: multiplier never answers, then a stale done arrives.
    mdl_en = 1'b0;
    rsp_ready = '0;
    req_a = $urandom;
    req_b = $urandom;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    wait_rsp(40, lat);
    check_eq("to_latency", lat, TMO + 1);
    check_eq("to_rsp_err", 32'(rsp_err), 1);
    check_eq("to_rsp_data", 32'(rsp_data), 0);
    mdl_late_req++;
    tick();
    tick();
    check_eq("to_late_err", 32'(rsp_err), 1);
    check_eq("to_late_data", 32'(rsp_data), 0);
    check_eq("to_late_valid", 32'(rsp_valid), 32'h1);
    base = n_rsp;
    rsp_ready = 2'b11;
    tick();
    mdl_en = 1'b1;
    check_eq("to_done", n_rsp, base + 1);
    mdl_late_req++;
    tick();
    tick();
    check_eq("to_idle_ignore", 32'(busy), 0);
`endif

    // Counter wrap over 256 back-to-back jobs.
    do_reset();
    mdl_delay = 1;
    rsp_ready = 2'b11;
    base = n_rsp;
    seen = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 4000 && n_rsp < base + 256; k++) begin
      tick();
      if (!seen && n_rsp == base + 255) begin
        seen = 1'b1;
        check_eq("wrap_255", 32'(job_count), 32'd255);
      end
    end
    req_valid = '0;
    check_eq("wrap_jobs", n_rsp, base + 256);
    check_eq("wrap_zero", 32'(job_count), 0);
    tick();
    check_eq("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/polymul_scheduler.md
Name: polymul_scheduler

Overview:
- Round-robin job scheduler sharing one polynomial multiplier datapath between N_REQ requesters.
- Accepts operand polynomials over valid/ready, issues a one-cycle start pulse to the multiplier, and waits for its done strobe.
- Returns the product to the owning requester over a per-requester valid/ready response channel.
- Sits between requester front-ends and the multiplier top level; holds multiplier operands stable for the whole job.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- N_COEF, 4, coefficients per polynomial.
- COEF_W, 4, bits per coefficient (mod-16 ring).
- TIMEOUT_CYCLES, 16, maximum WAIT duration; used only with the timeout feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester job request.
- req_ready  out  N_REQ  one-hot grant/accept.
- req_a  in  N_REQ*N_COEF*COEF_W  packed operand A per requester; requester i occupies slice i.
- req_b  in  N_REQ*N_COEF*COEF_W  packed operand B per requester.
- rsp_valid  out  N_REQ  one-hot result valid to the job owner.
- rsp_ready  in  N_REQ  per-requester result accept.
- rsp_data  out  N_COEF*COEF_W  result polynomial.
- rsp_err  out  1  result is a timeout, not a product.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  N_COEF*COEF_W  operand A to the multiplier.
- mul_b  out  N_COEF*COEF_W  operand B to the multiplier.
- mul_done  in  1  multiplier completion strobe.
- mul_result  in  N_COEF*COEF_W  multiplier product, valid with mul_done.
- busy  out  1  high in any state other than IDLE.
- job_count  out  8  count of completed responses.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including operand and result registers and job_count.
  - last_grant is set to N_REQ-1, so requester 0 has first priority.
  - Reset mid-job abandons the job silently; no response is ever issued for it.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Round-robin search starts at last_grant+1 and wraps; it picks the first requester with req_valid set.
  - req_ready is driven combinationally, one-hot to the chosen requester, and only in IDLE.
  - On the handshake: capture that requester's req_a/req_b into the operand registers, set owner to its index, go to ISSUE.
- ISSUE:
  - mul_start=1 for exactly one cycle; go to WAIT.
  - mul_a/mul_b carry the operand registers from ISSUE through RESP.
- WAIT:
  - On mul_done, capture mul_result into rsp_data, set rsp_err=0, go to RESP.
  - mul_done is ignored in every state except WAIT.
- RESP:
  - rsp_valid[owner]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[owner], in the same edge: go to IDLE, set last_grant to owner, increment job_count (wraps 255 to 0).
  - rsp_ready bits of other requesters are ignored.
- Latency:
  - Request handshake at cycle T gives mul_start at T+1.
  - mul_done at cycle D gives rsp_valid from D+1.
  - There is at least one bubble cycle between a response handshake and the next request acceptance.
- One job is in flight at a time; no buffering of requests.

Optional Feature:
- Macro: POLYMUL_SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit WAIT timer clears in ISSUE and counts every cycle spent in WAIT.
  - When it reaches TIMEOUT_CYCLES without mul_done: go to RESP with rsp_data=0 and rsp_err=1.
  - mul_done in the same cycle the limit is reached wins (normal result).
  - A late mul_done after the timeout is ignored.
- Undefined: no timer; WAIT lasts indefinitely; rsp_err is tied to 0.

Decomposition:
- Package polymul_pkg holds:
  - N_COEF, COEF_W, and POLY_W=N_COEF*COEF_W;
  - the FSM state enum;
  - the default TIMEOUT_CYCLES.
- One sub-module: rr_arbiter. Inputs req_valid and last_grant; outputs a one-hot grant and the granted index; purely combinational.

Test Plan:
- Single job:
  - Stimulus: after reset, req_valid=01, req_a[0]=16'h0008, req_b[0]=16'h0865; model returns 16'h1234 three cycles after start.
  - Response: mul_start one cycle after the handshake with mul_a=16'h0008; rsp_valid=01 the cycle after mul_done; rsp_data=16'h1234; job_count=1.
- Fairness: req_valid=11 held for 4 jobs -> grants alternate 0,1,0,1; rsp_valid matches each owner.
- Back-pressure: rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_data held constant; req_ready stays 0; no second mul_start.
- Reset in WAIT: reset low for one cycle -> all outputs 0 immediately; no rsp_valid; the next req_valid=11 is granted to requester 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8): mul_done never asserts -> RESP entered 8 WAIT cycles after mul_start with rsp_err=1 and rsp_data=0; a mul_done issued later is ignored.
- Wrap: 256 back-to-back completed jobs -> job_count returns to 0.
